// File: rtl/adaptive_binarization_pkg.sv
// Shared helpers and state encodings for the adaptive binarization stage.
package adaptive_binarization_pkg;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

    // Pixel counter width able to hold max_pixels without wrapping.
    function automatic int unsigned cnt_width(input int unsigned max_pixels);
        return clog2(max_pixels + 1);
    endfunction

    typedef enum logic [2:0] {
        StIdle,
        StDiv,
        StCalc,
        StCommit,
        StHold
    } thr_state_e;

endpackage

// File: rtl/adaptive_binarization_seq_div.sv
// Restoring sequential unsigned divider: one quotient bit per cycle, NUM_W
// iterations after the start cycle. start has priority over abort.
module adaptive_binarization_seq_div
    import adaptive_binarization_pkg::*;
#(
    parameter int unsigned NUM_W = 25,
    parameter int unsigned DEN_W = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [NUM_W-1:0] num_i,
    input  logic [DEN_W-1:0] den_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [NUM_W-1:0] quo_o
);

    localparam int unsigned CntW = clog2(NUM_W + 1);

    logic [DEN_W-1:0] rem_q, rem_d;
    logic [NUM_W-1:0] quo_q, quo_d;
    logic [DEN_W-1:0] den_q;
    logic [CntW-1:0]  cnt_q;
    logic             busy_q, done_q;
    logic [DEN_W:0]   shifted;
    logic [DEN_W:0]   diff;

    // One restoring step: shift in next dividend bit, subtract if it fits.
    always_comb begin
        shifted = {rem_q, quo_q[NUM_W-1]};
        diff    = shifted - {1'b0, den_q};
        rem_d   = shifted[DEN_W-1:0];
        quo_d   = {quo_q[NUM_W-2:0], 1'b0};
        if (shifted >= {1'b0, den_q}) begin
            rem_d = diff[DEN_W-1:0];
            quo_d = {quo_q[NUM_W-2:0], 1'b1};
        end
    end

    // Iteration control and operand registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            quo_q  <= '0;
            den_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                rem_q  <= '0;
                quo_q  <= num_i;
                den_q  <= den_i;
                cnt_q  <= CntW'(NUM_W);
                busy_q <= 1'b1;
            end else if (abort_i) begin
                busy_q <= 1'b0;
            end else if (busy_q) begin
                rem_q <= rem_d;
                quo_q <= quo_d;
                cnt_q <= cnt_q - 1'b1;
                if (cnt_q == CntW'(1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign quo_o  = quo_q;

endmodule

// File: rtl/adaptive_binarization.sv
// Luma binarization with manual or per-frame adaptive (mean + offset)
// threshold. Two-stage output pipeline; threshold changes only between frames.
module adaptive_binarization
    import adaptive_binarization_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned MAX_PIXELS  = 130560,
    parameter int unsigned INIT_THRESH = 128,
    parameter int unsigned OFS_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pre_frame_vsync,
    input  logic              pre_frame_hsync,
    input  logic              pre_frame_de,
    input  logic [DATA_W-1:0] color,
    input  logic              mode,
    input  logic [DATA_W-1:0] manual_thresh,
    input  logic [OFS_W-1:0]  thresh_offset,
    input  logic              invert,
    output logic              post_frame_vsync,
    output logic              post_frame_hsync,
    output logic              post_frame_de,
    output logic              monoc,
    output logic              monoc_fall,
    output logic [DATA_W-1:0] cur_thresh,
    output logic              thresh_update
);

    localparam int unsigned CNT_W = cnt_width(MAX_PIXELS);
    localparam int unsigned SUM_W = DATA_W + CNT_W;
    localparam int unsigned T_W   = SUM_W + 2;

    logic              vs1_q, hs1_q, de1_q, cmp_q;
    logic              vs2_q, hs2_q, de2_q, monoc_q, fall_q;
    logic              cmp_d, vs_edge;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SUM_W:0]    sum_ext;
    logic              seen_de_q, seen_de_d;
    thr_state_e        state_q;
    logic [DATA_W-1:0] result_q, cur_thresh_q, clamp_d;
    logic              update_q;
    logic              div_start, div_busy, div_done;
    logic [SUM_W-1:0]  div_quo;
    logic [T_W-1:0]    t_sum;

    // vs1_q doubles as the previous-vsync register for edge detection.
    assign vs_edge   = pre_frame_vsync & ~vs1_q;
    assign cmp_d     = pre_frame_de & (invert ? (color < cur_thresh_q) : (color > cur_thresh_q));
    assign div_start = vs_edge & mode & (cnt_q != '0);

    // S1 registers the compare, S2 the outputs; fall needs both pixels in the line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {vs1_q, hs1_q, de1_q, cmp_q}          <= '0;
            {vs2_q, hs2_q, de2_q, monoc_q, fall_q} <= '0;
        end else begin
            vs1_q   <= pre_frame_vsync;
            hs1_q   <= pre_frame_hsync;
            de1_q   <= pre_frame_de;
            cmp_q   <= cmp_d;
            vs2_q   <= vs1_q;
            hs2_q   <= hs1_q;
            de2_q   <= de1_q;
            monoc_q <= cmp_q;
            // monoc_q is already 0 outside de, so a new line starts from a clear history.
            fall_q  <= monoc_q & ~cmp_q & de1_q;
        end
    end

    // Saturating frame accumulators; a vsync edge starts the new frame's totals.
    always_comb begin
        sum_ext   = {1'b0, sum_q} + (SUM_W + 1)'(color);
        sum_d     = sum_q;
        cnt_d     = cnt_q;
        seen_de_d = seen_de_q | pre_frame_de;
        if (vs_edge) begin
            sum_d     = pre_frame_de ? SUM_W'(color) : '0;
            cnt_d     = CNT_W'(pre_frame_de);
            seen_de_d = pre_frame_de;
        end else if (pre_frame_de) begin
            sum_d = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        end
    end

    // Accumulator state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q     <= '0;
            cnt_q     <= '0;
            seen_de_q <= 1'b0;
        end else begin
            sum_q     <= sum_d;
            cnt_q     <= cnt_d;
            seen_de_q <= seen_de_d;
        end
    end

    // Frame totals are captured by the divider itself on start.
    adaptive_binarization_seq_div #(
        .NUM_W(SUM_W),
        .DEN_W(CNT_W)
    ) u_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .start_i(div_start),
        .abort_i(vs_edge),
        .num_i  (sum_q),
        .den_i  (cnt_q),
        .busy_o (div_busy),
        .done_o (div_done),
        .quo_o  (div_quo)
    );

    // mean + sign-extended offset, clamped to the luma range.
    always_comb begin
        t_sum = {2'b00, div_quo} + {{(T_W - OFS_W){thresh_offset[OFS_W-1]}}, thresh_offset};
        if (t_sum[T_W-1]) begin
            clamp_d = '0;
        end else if (|t_sum[T_W-2:DATA_W]) begin
            clamp_d = '1;
        end else begin
            clamp_d = t_sum[DATA_W-1:0];
        end
    end

    // Threshold FSM; a pending result always lands before a new frame is handled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            result_q     <= '0;
            cur_thresh_q <= DATA_W'(INIT_THRESH);
            update_q     <= 1'b0;
        end else begin
            update_q <= 1'b0;
            if (vs_edge) begin
                if (state_q == StHold || state_q == StCommit) begin
                    cur_thresh_q <= result_q;
                    update_q     <= 1'b1;
                end
                if (!mode) begin
                    result_q <= manual_thresh;
                    state_q  <= StCommit;
                end else if (cnt_q != '0) begin
                    state_q <= StDiv;
                end else begin
                    state_q <= StIdle;
                end
            end else begin
                unique case (state_q)
                    StIdle: state_q <= StIdle;
                    StDiv: begin
                        if (div_done) state_q <= StCalc;
                        else if (!div_busy) state_q <= StIdle;
                    end
                    StCalc: begin
                        result_q <= clamp_d;
                        state_q  <= StCommit;
                    end
                    StCommit: begin
                        // Never change the threshold once this frame has shown a pixel.
                        if (seen_de_q || pre_frame_de) begin
                            state_q <= StHold;
                        end else begin
                            cur_thresh_q <= result_q;
                            update_q     <= 1'b1;
                            state_q      <= StIdle;
                        end
                    end
                    StHold: state_q <= StHold;
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign post_frame_vsync = vs2_q;
    assign post_frame_hsync = hs2_q;
    assign post_frame_de    = de2_q;
    assign monoc            = monoc_q;
    assign monoc_fall       = fall_q;
    assign cur_thresh       = cur_thresh_q;
    assign thresh_update    = update_q;

endmodule

// File: tb/tb_adaptive_binarization.sv
// Directed bench for adaptive_binarization: compare polarity, fall pulses,
// manual/adaptive threshold commits, clamping, deferral and reset.
module tb_adaptive_binarization;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pre_frame_vsync, pre_frame_hsync, pre_frame_de;
    logic [7:0] color;
    logic       mode;
    logic [7:0] manual_thresh;
    logic [7:0] thresh_offset;
    logic       invert;
    logic       post_frame_vsync, post_frame_hsync, post_frame_de;
    logic       monoc, monoc_fall;
    logic [7:0] cur_thresh;
    logic       thresh_update;

    int checks = 0;
    int errors = 0;

    adaptive_binarization dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pre_frame_vsync (pre_frame_vsync),
        .pre_frame_hsync (pre_frame_hsync),
        .pre_frame_de    (pre_frame_de),
        .color           (color),
        .mode            (mode),
        .manual_thresh   (manual_thresh),
        .thresh_offset   (thresh_offset),
        .invert          (invert),
        .post_frame_vsync(post_frame_vsync),
        .post_frame_hsync(post_frame_hsync),
        .post_frame_de   (post_frame_de),
        .monoc           (monoc),
        .monoc_fall      (monoc_fall),
        .cur_thresh      (cur_thresh),
        .thresh_update   (thresh_update)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] color;
        logic       inv;
        logic       exp;
    } vec_t;

    vec_t vecs[8];

    // Slot stimulus for the fall test: de, luma and hsync per cycle.
    logic       s_de[14];
    logic [7:0] s_col[14];
    logic       s_hs[14];
    logic       e_mono[14];
    logic       e_fall[14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One frame: vsync edge, blank cycles without de, npix pixels of val, 4 idle cycles.
    task automatic run_frame(input int blank, input int npix, input logic [7:0] val,
                             output int upd_blank, output int upd_active);
        upd_blank  = 0;
        upd_active = 0;
        for (int c = 0; c < blank; c++) begin
            pre_frame_vsync = (c < 3);
            pre_frame_de    = 1'b0;
            tick();
            upd_blank += int'(thresh_update);
        end
        for (int p = 0; p < npix + 4; p++) begin
            pre_frame_de = (p < npix);
            color        = val;
            tick();
            upd_active += int'(thresh_update);
        end
        pre_frame_de = 1'b0;
    endtask

    initial begin
        int ub, ua, cnt;

        vecs[0] = '{8'd99,  1'b0, 1'b0};
        vecs[1] = '{8'd100, 1'b0, 1'b0};
        vecs[2] = '{8'd101, 1'b0, 1'b1};
        vecs[3] = '{8'd99,  1'b1, 1'b1};
        vecs[4] = '{8'd100, 1'b1, 1'b0};
        vecs[5] = '{8'd101, 1'b1, 1'b0};
        vecs[6] = '{8'd0,   1'b0, 1'b0};
        vecs[7] = '{8'd255, 1'b0, 1'b1};

        // Line 0,1,0,0 | gap | 1,1,0,1 | gap | 0 ; 1 = 200, 0 = 0 at th 100.
        for (int i = 0; i < 14; i++) begin
            s_de[i] = 1'b0; s_col[i] = 8'd0; s_hs[i] = 1'b0;
            e_mono[i] = 1'b0; e_fall[i] = 1'b0;
        end
        s_de[0] = 1; s_de[1] = 1; s_de[2] = 1; s_de[3] = 1;
        s_de[6] = 1; s_de[7] = 1; s_de[8] = 1; s_de[9] = 1; s_de[11] = 1;
        s_col[1] = 8'd200; s_col[6] = 8'd200; s_col[7] = 8'd200; s_col[9] = 8'd200;
        s_hs[4] = 1; s_hs[10] = 1;
        e_mono[1] = 1; e_mono[6] = 1; e_mono[7] = 1; e_mono[9] = 1;
        e_fall[2] = 1; e_fall[8] = 1;

        rst_n = 1'b0;
        pre_frame_vsync = 0; pre_frame_hsync = 0; pre_frame_de = 0;
        color = 0; mode = 0; manual_thresh = 8'd100; thresh_offset = 0; invert = 0;
        tick(); tick();
        check("rst_thresh", 32'(cur_thresh), 32'd128);
        check("rst_monoc", 32'(monoc), 32'd0);
        check("rst_update", 32'(thresh_update), 32'd0);
        rst_n = 1'b1;
        tick();

        // Manual threshold committed once at the vsync edge.
        run_frame(40, 0, 8'd0, ub, ua);
        check("manual_upd", 32'(ub), 32'd1);
        check("manual_thresh", 32'(cur_thresh), 32'd100);

        // Compare polarity and equality handling.
        for (int i = 0; i < 8; i++) begin
            color = vecs[i].color; invert = vecs[i].inv; pre_frame_de = 1'b1;
            tick();
            pre_frame_de = 1'b0;
            tick();
            check($sformatf("vec%0d_monoc", i), 32'(monoc), 32'(vecs[i].exp));
            check($sformatf("vec%0d_de", i), 32'(post_frame_de), 32'd1);
            tick();
            check($sformatf("vec%0d_idle", i), 32'(monoc), 32'd0);
        end
        invert = 1'b0;

        // Fall pulses across lines; outputs lag inputs by two cycles.
        for (int i = 0; i < 14; i++) begin
            pre_frame_de = s_de[i]; color = s_col[i]; pre_frame_hsync = s_hs[i];
            tick();
            if (i >= 1) begin
                check($sformatf("fall_s%0d", i - 1), 32'(monoc_fall), 32'(e_fall[i-1]));
                check($sformatf("mono_s%0d", i - 1), 32'(monoc), 32'(e_mono[i-1]));
                check($sformatf("hs_s%0d", i - 1), 32'(post_frame_hsync), 32'(s_hs[i-1]));
            end
        end
        pre_frame_de = 0; pre_frame_hsync = 0;

        // Adaptive: frame of 60 with +10 commits 70 in the next blanking.
        mode = 1'b1; thresh_offset = 8'sd10;
        run_frame(40, 16, 8'd60, ub, ua);
        run_frame(40, 16, 8'd50, ub, ua);
        check("adapt_upd", 32'(ub), 32'd1);
        check("adapt_thresh", 32'(cur_thresh), 32'd70);
        check("adapt_upd_active", 32'(ua), 32'd0);

        // Clamp at both ends.
        thresh_offset = -8'sd100;
        run_frame(40, 16, 8'd200, ub, ua);
        check("clamp_low", 32'(cur_thresh), 32'd0);
        thresh_offset = 8'sd100;
        run_frame(40, 16, 8'd60, ub, ua);
        check("clamp_high", 32'(cur_thresh), 32'd255);

        // Short blanking: result (60) is held, threshold stays for this frame.
        thresh_offset = 8'sd0;
        run_frame(10, 16, 8'd100, ub, ua);
        check("defer_upd_blank", 32'(ub), 32'd0);
        check("defer_upd_active", 32'(ua), 32'd0);
        check("defer_thresh", 32'(cur_thresh), 32'd255);

        // Next edge commits the held result, then a fresh divide yields 100.
        pre_frame_vsync = 1'b1;
        tick();
        check("hold_commit_upd", 32'(thresh_update), 32'd1);
        check("hold_commit_thresh", 32'(cur_thresh), 32'd60);
        cnt = 0;
        for (int c = 1; c < 40; c++) begin
            pre_frame_vsync = (c < 3);
            tick();
            cnt += int'(thresh_update);
        end
        check("fresh_upd", 32'(cnt), 32'd1);
        check("fresh_thresh", 32'(cur_thresh), 32'd100);

        // Frame with no pixels: threshold kept, no update.
        run_frame(40, 0, 8'd0, ub, ua);
        check("empty_upd", 32'(ub), 32'd0);
        check("empty_thresh", 32'(cur_thresh), 32'd100);

        // Asynchronous reset in the middle of active pixels.
        pre_frame_de = 1'b1; color = 8'd200;
        tick(); tick();
        check("pre_rst_monoc", 32'(monoc), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_monoc", 32'(monoc), 32'd0);
        check("arst_de", 32'(post_frame_de), 32'd0);
        check("arst_thresh", 32'(cur_thresh), 32'd128);
        pre_frame_de = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
